// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAIL
  } seq_state_t;

  // One counter is shared by every state, so it must hold the largest count.
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles);
    int w;
    w = $clog2(rst_cycles);
    if ($clog2(timeout_cycles) > w) w = $clog2(timeout_cycles);
    if ($clog2(stable_cycles + 1) > w) w = $clog2(stable_cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, qualifies lock, and releases downstream reset only once
// lock has been stable; retries on lock timeout and reports failure.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             locked,
  input  logic                             soft_rst_req,
  input  logic                             retry_req,
  output logic                             pll_rst,
  output logic                             sys_rst_n,
  output logic                             ready,
  output logic                             fail,
  output logic                             lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  // Compared against the pre-increment count, which lands RUN exactly
  // LOCK_STABLE_CYCLES+1 edges after the synced lock is first seen.
  localparam logic [CW-1:0] STAB_DONE = CW'(LOCK_STABLE_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic          locked_s;
  seq_state_t    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [RW-1:0] nxt_retry;
  logic          nxt_lost;

  sync_bit #(.STAGES(LOCK_SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    nxt_lost  = lock_lost;
    if (soft_rst_req) begin
      nxt_state = PLL_RESET;
      nxt_retry = '0;
      nxt_lost  = 1'b0;
    end else begin
      case (state)
        PLL_RESET: if (cnt == RST_LAST) nxt_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) nxt_state = STABILIZE;
          else if (cnt == TMO_LAST) begin
            if (retry_cnt == RETRY_MAX) nxt_state = FAIL;
            else begin
              nxt_state = PLL_RESET;
              nxt_retry = retry_cnt + 1'b1;
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) nxt_state = WAIT_LOCK;
          else if (cnt == STAB_DONE) nxt_state = RUN;
        end
        RUN: if (!locked_s) begin
          nxt_state = PLL_RESET;
          nxt_retry = '0;
          nxt_lost  = 1'b1;
        end
        FAIL: if (retry_req) begin
          nxt_state = PLL_RESET;
          nxt_retry = '0;
        end
        default: nxt_state = PLL_RESET;
      endcase
    end
    // soft_rst_req inside PLL_RESET restarts the pulse without a state change
    if (soft_rst_req || nxt_state != state || state == RUN || state == FAIL) nxt_cnt = '0;
    else nxt_cnt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RESET;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      retry_cnt <= nxt_retry;
      lock_lost <= nxt_lost;
      pll_rst   <= (nxt_state == PLL_RESET);
      sys_rst_n <= (nxt_state == RUN);
      ready     <= (nxt_state == RUN);
      fail      <= (nxt_state == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: vector table, directed corner sequences and a
// random run, all cross-checked against a timestamp-based reference model.
module tb_pll_lock_sequencer;

  localparam int PRC = 4, LTC = 32, LSC = 8, MR = 2, LSS = 2;

  logic       clk = 1'b0, rst_n = 1'b0, locked = 1'b0, soft_rst_req = 1'b0, retry_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [6:0] dut_out;

  int total = 0, bad = 0;

  always #10 clk = ~clk;

  pll_lock_sequencer #(
    .LOCK_SYNC_STAGES(LSS), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(LTC),
    .LOCK_STABLE_CYCLES(LSC), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst_req(soft_rst_req),
    .retry_req(retry_req), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  // {pll_rst, sys_rst_n, ready, fail, lock_lost, retry_cnt[1:0]}
  assign dut_out = {pll_rst, sys_rst_n, ready, fail, lock_lost, retry_cnt};

  // Reference model: phase plus the edge it was entered on; durations are
  // elapsed-edge differences, and the synced lock is the raw sample LSS edges ago.
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mmode_t;
  mmode_t m_mode = M_RST;
  int     m_edge = 0, m_entry = 0, m_retry = 0;
  bit     m_lost = 1'b0;
  bit     hist[$];

  function automatic void model_reset();
    m_mode = M_RST; m_edge = 0; m_entry = 0; m_retry = 0; m_lost = 1'b0;
    hist.delete();
  endfunction

  function automatic void model_step(input bit l, input bit s, input bit r);
    bit ls;
    int el;
    mmode_t nm;
    m_edge++;
    ls = (hist.size() >= LSS) ? hist[hist.size()-LSS] : 1'b0;
    hist.push_back(l);
    if (hist.size() > 8) void'(hist.pop_front());
    el = m_edge - m_entry;
    nm = m_mode;
    if (s) begin
      nm = M_RST; m_retry = 0; m_lost = 1'b0; m_entry = m_edge;
    end else begin
      case (m_mode)
        M_RST:  if (el == PRC) nm = M_WAIT;
        M_WAIT: begin
          if (ls) nm = M_STAB;
          else if (el == LTC) begin
            if (m_retry == MR) nm = M_FAIL;
            else begin m_retry++; nm = M_RST; end
          end
        end
        // ready lands LSS+LSC+1 edges after the raw rise, i.e. LSC+1 after entry
        M_STAB: if (!ls) nm = M_WAIT; else if (el == LSC + 1) nm = M_RUN;
        M_RUN:  if (!ls) begin nm = M_RST; m_lost = 1'b1; m_retry = 0; end
        M_FAIL: if (r) begin nm = M_RST; m_retry = 0; end
        default: ;
      endcase
    end
    if (nm != m_mode) m_entry = m_edge;
    m_mode = nm;
  endfunction

  function automatic logic [6:0] model_out();
    return {m_mode == M_RST, m_mode == M_RUN, m_mode == M_RUN, m_mode == M_FAIL,
            m_lost, 2'(m_retry)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a rising edge; outputs are checked 1ns after the next one.
  task automatic cyc(input bit l, input bit s, input bit r);
    locked = l; soft_rst_req = s; retry_req = r;
    @(posedge clk);
    model_step(l, s, r);
    #1 chk("model", dut_out, model_out());
  endtask

  // Assert rst_n between edges and check that outputs respond with no clock.
  task automatic do_reset(input string name);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk(name, dut_out, 7'b1000000);
    model_reset();
    locked = 1'b0; soft_rst_req = 1'b0; retry_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    int         n;
    bit         l, s, r;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // first bring-up: locked rises at edge N=11, ready at N+11
    tbl.push_back('{1, 3,  0, 0, 0, 7'b1000000, "t1 pll_rst held"});
    tbl.push_back('{0, 1,  0, 0, 0, 7'b0000000, "t1 pll_rst 4 cycles"});
    tbl.push_back('{0, 6,  0, 0, 0, 7'b0000000, "t1 wait lock"});
    tbl.push_back('{0, 10, 1, 0, 0, 7'b0000000, "t1 stabilizing"});
    tbl.push_back('{0, 1,  1, 0, 0, 7'b0000000, "t1 not yet ready"});
    tbl.push_back('{0, 1,  1, 0, 0, 7'b0110000, "t1 ready at N+11"});
    // no lock ever: two retries, then FAIL, then retry_req
    tbl.push_back('{1, 4,  0, 0, 0, 7'b0000000, "t2 first wait"});
    tbl.push_back('{0, 32, 0, 0, 0, 7'b1000001, "t2 retry 1"});
    tbl.push_back('{0, 4,  0, 0, 0, 7'b0000001, "t2 second wait"});
    tbl.push_back('{0, 32, 0, 0, 0, 7'b1000010, "t2 retry 2"});
    tbl.push_back('{0, 4,  0, 0, 0, 7'b0000010, "t2 third wait"});
    tbl.push_back('{0, 31, 0, 0, 0, 7'b0000010, "t2 before fail"});
    tbl.push_back('{0, 1,  0, 0, 0, 7'b0001010, "t2 fail"});
    tbl.push_back('{0, 5,  0, 0, 0, 7'b0001010, "t2 fail holds"});
    tbl.push_back('{0, 1,  0, 0, 1, 7'b1000000, "t2 retry_req"});
    tbl.push_back('{0, 3,  0, 0, 0, 7'b1000000, "t2 pulse held"});
    tbl.push_back('{0, 1,  0, 0, 0, 7'b0000000, "t2 pulse ends"});

    do_reset("reset state");
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset("reset state");
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].l, tbl[i].s, tbl[i].r);
      chk(tbl[i].name, dut_out, tbl[i].exp);
    end

    // t3: 5 high, 1 low glitch, then steady lock
    do_reset("reset state");
    repeat (4) cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (11) cyc(1, 0, 0);
    chk("t3 no early run", dut_out, 7'b0000000);
    cyc(1, 0, 0);
    chk("t3 run after glitch", dut_out, 7'b0110000);

    // t4: 3-cycle lock drop while running
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t4 ready before sync", dut_out, 7'b0110000);
    cyc(0, 0, 0);
    chk("t4 drop two edges", dut_out, 7'b1000100);
    repeat (3) cyc(1, 0, 0);
    chk("t4 pll_rst held", dut_out, 7'b1000100);
    cyc(1, 0, 0);
    chk("t4 pll_rst 4 cycles", dut_out, 7'b0000100);
    repeat (9) cyc(1, 0, 0);
    chk("t4 relock pending", dut_out, 7'b0000100);
    cyc(1, 0, 0);
    chk("t4 relock run", dut_out, 7'b0110100);

    // t5: soft reset collides with the final timeout
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("t5 lost again", dut_out, 7'b1000100);
    repeat (107) cyc(0, 0, 0);
    chk("t5 last wait", dut_out, 7'b0000110);
    cyc(0, 1, 0);
    chk("t5 soft beats fail", dut_out, 7'b1000000);
    cyc(0, 0, 0);

    // t6: async reset in STABILIZE, then replay
    do_reset("reset state");
    repeat (4) cyc(0, 0, 0);
    repeat (4) cyc(1, 0, 0);
    chk("t6 in stabilize", dut_out, 7'b0000000);
    do_reset("t6 async reset");
    repeat (13) cyc(1, 0, 0);
    chk("t6 replay pending", dut_out, 7'b0000000);
    cyc(1, 0, 0);
    chk("t6 replay run", dut_out, 7'b0110000);

    // random lock behaviour with occasional soft/retry pulses and resets
    do_reset("reset state");
    begin
      int hold = 0;
      bit l = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        if (hold == 0) begin
          l = 1'($urandom_range(0, 1));
          hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 14);
        end
        hold--;
        if ($urandom_range(0, 999) == 0) do_reset("random reset");
        cyc(l, $urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0);
      end
    end
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
